fe_uop_queue: RTL and testbench

//  Decoupling FIFO between the frontend decode output and the OOO rename/allocate stage.

---
 rtl/fe_pkg.sv | 23 ++
 rtl/fe_uop_queue_if.sv | 48 ++++
 rtl/fe_uop_queue_mem.sv | 23 ++
 rtl/fe_uop_queue.sv | 99 +++++++++
 tb/tb_fe_uop_queue.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fe_pkg.sv
// Types shared by the decode, uop-queue and rename interfaces.
// fe_uop_t is the packed uop record that flows from decode to rename.
package fe_pkg;
  localparam int XLEN  = 32;
  localparam int UOP_W = 8;
  localparam int REG_W = 5;
  localparam int BHR_W = 10;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic             eoi;
    logic [REG_W-1:0] dr;
    logic [REG_W-1:0] sr1;
    logic [REG_W-1:0] sr2;
    logic [XLEN-1:0]  imm;
    logic             use_imm;
    logic [XLEN-1:0]  pc;
    logic             exception;
    logic [BHR_W-1:0] bhr;
  } fe_uop_t;

  localparam int FE_UOP_W = $bits(fe_uop_t);
endpackage

// File: rtl/fe_uop_queue_if.sv
// Decode-to-rename uop queue bundle: enqueue side, dequeue side, status.
// master is the surrounding pipeline; slave is the queue itself.
interface fe_uop_queue_if
  import fe_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             enq_valid;
  logic [UOP_W-1:0] enq_uop;
  logic             enq_eoi;
  logic [REG_W-1:0] enq_dr, enq_sr1, enq_sr2;
  logic [XLEN-1:0]  enq_imm;
  logic             enq_use_imm;
  logic [XLEN-1:0]  enq_pc;
  logic             enq_exception;
  logic [BHR_W-1:0] enq_bhr;
  logic             stall_out;

  logic             deq_valid;
  logic             deq_ready;
  logic [UOP_W-1:0] deq_uop;
  logic             deq_eoi;
  logic [REG_W-1:0] deq_dr, deq_sr1, deq_sr2;
  logic [XLEN-1:0]  deq_imm;
  logic             deq_use_imm;
  logic [XLEN-1:0]  deq_pc;
  logic             deq_exception;
  logic [BHR_W-1:0] deq_bhr;
  logic [CW-1:0]    count;
  logic             overflow;

  modport master (
    output flush, enq_valid, enq_uop, enq_eoi, enq_dr, enq_sr1, enq_sr2,
           enq_imm, enq_use_imm, enq_pc, enq_exception, enq_bhr, deq_ready,
    input  stall_out, deq_valid, deq_uop, deq_eoi, deq_dr, deq_sr1, deq_sr2,
           deq_imm, deq_use_imm, deq_pc, deq_exception, deq_bhr, count, overflow
  );

  modport slave (
    input  flush, enq_valid, enq_uop, enq_eoi, enq_dr, enq_sr1, enq_sr2,
           enq_imm, enq_use_imm, enq_pc, enq_exception, enq_bhr, deq_ready,
    output stall_out, deq_valid, deq_uop, deq_eoi, deq_dr, deq_sr1, deq_sr2,
           deq_imm, deq_use_imm, deq_pc, deq_exception, deq_bhr, count, overflow
  );
endinterface

// File: rtl/fe_uop_queue_mem.sv
// Uop storage: DEPTH flop entries, one write port, one combinational read port.
// Contents are intentionally not reset; occupancy tracking lives in the parent.
module fe_uop_queue_mem
  import fe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [FE_UOP_W-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [FE_UOP_W-1:0] o_rdata
);
  logic [FE_UOP_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fe_uop_queue.sv
// Decoupling FIFO between decode and rename, with early frontend stall,
// resteer flush and a sticky overflow flag for dropped enqueues.
module fe_uop_queue
  import fe_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int STALL_THRESH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fe_uop_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_stall, r_overflow;
  logic          w_deq_fire, w_enq_fire, w_drop;
  fe_uop_t       w_wdata, w_rdata;

  assign w_deq_fire = (r_count != '0) && q.deq_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_enq_fire = q.enq_valid && ((r_count < CW'(DEPTH)) || w_deq_fire) && !q.flush;
  assign w_drop     = q.enq_valid && !q.flush && (r_count == CW'(DEPTH)) && !w_deq_fire;

  always_comb begin
    w_count_next = r_count;
    if (q.flush) begin
      w_count_next = '0;
    end else begin
      case ({w_enq_fire, w_deq_fire})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (q.flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq_fire) r_tail <= r_tail + AW'(1);
        if (w_deq_fire) r_head <= r_head + AW'(1);
      end
      r_count <= w_count_next;
      // Registered from the next occupancy so the frontend sees it one cycle sooner.
      r_stall <= (w_count_next >= CW'(DEPTH - STALL_THRESH)) && !q.flush;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_wdata           = '0;
    w_wdata.uop       = q.enq_uop;
    w_wdata.eoi       = q.enq_eoi;
    w_wdata.dr        = q.enq_dr;
    w_wdata.sr1       = q.enq_sr1;
    w_wdata.sr2       = q.enq_sr2;
    w_wdata.imm       = q.enq_imm;
    w_wdata.use_imm   = q.enq_use_imm;
    w_wdata.pc        = q.enq_pc;
    w_wdata.exception = q.enq_exception;
    w_wdata.bhr       = q.enq_bhr;
  end

  fe_uop_queue_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_enq_fire),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_rdata)
  );

  assign q.deq_valid     = (r_count != '0);
  assign q.deq_uop       = w_rdata.uop;
  assign q.deq_eoi       = w_rdata.eoi;
  assign q.deq_dr        = w_rdata.dr;
  assign q.deq_sr1       = w_rdata.sr1;
  assign q.deq_sr2       = w_rdata.sr2;
  assign q.deq_imm       = w_rdata.imm;
  assign q.deq_use_imm   = w_rdata.use_imm;
  assign q.deq_pc        = w_rdata.pc;
  assign q.deq_exception = w_rdata.exception;
  assign q.deq_bhr       = w_rdata.bhr;
  assign q.count         = r_count;
  assign q.stall_out     = r_stall;
  assign q.overflow      = r_overflow;
endmodule

// File: tb/tb_fe_uop_queue.sv
// Directed bench for fe_uop_queue (DEPTH=8, STALL_THRESH=2): fill/stall/overflow,
// full enq+deq, streaming across pointer wrap, flush, and asynchronous reset.
module tb_fe_uop_queue;
  import fe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fe_uop_queue_if #(.DEPTH(8)) bus ();

  fe_uop_queue #(.DEPTH(8), .STALL_THRESH(2)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      $display("[%0t] ok   %s = %0h", $time, tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [31:0] pc, input logic eoi);
    bus.enq_valid     = 1'b1;
    bus.enq_pc        = pc;
    bus.enq_eoi       = eoi;
    bus.enq_uop       = pc[7:0] ^ 8'h5a;
    bus.enq_dr        = pc[4:0];
    bus.enq_sr1       = pc[5:1];
    bus.enq_sr2       = pc[6:2];
    bus.enq_imm       = ~pc;
    bus.enq_use_imm   = pc[0];
    bus.enq_exception = pc[1];
    bus.enq_bhr       = pc[9:0];
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;
    bus.flush       = 1'b0;
    bus.enq_valid   = 1'b0;
    bus.deq_ready   = 1'b0;
    drive_enq(32'h0, 1'b0);
    bus.enq_valid   = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_stall", 64'(bus.stall_out), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);

    // 1: single enqueue, visible one cycle later
    drive_enq(32'h100, 1'b1);
    tick();
    bus.enq_valid = 1'b0;
    check("t1_deq_valid", 64'(bus.deq_valid), 64'd1);
    check("t1_deq_pc", 64'(bus.deq_pc), 64'h100);
    check("t1_deq_eoi", 64'(bus.deq_eoi), 64'd1);
    check("t1_deq_uop", 64'(bus.deq_uop), 64'h5a);
    check("t1_deq_imm", 64'(bus.deq_imm), 64'hffff_feff);
    check("t1_count", 64'(bus.count), 64'd1);
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    check("t1_drain_count", 64'(bus.count), 64'd0);

    // 2: fill to threshold, then full, then overflow
    for (int i = 0; i < 6; i++) begin
      drive_enq(32'h200 + 32'(i), 1'(i % 2));
      tick();
      if (i == 4) check("t2_stall_at5", 64'(bus.stall_out), 64'd0);
    end
    check("t2_count6", 64'(bus.count), 64'd6);
    check("t2_stall_at6", 64'(bus.stall_out), 64'd1);
    for (int i = 6; i < 8; i++) begin
      drive_enq(32'h200 + 32'(i), 1'b1);
      tick();
    end
    check("t2_count8", 64'(bus.count), 64'd8);
    check("t2_no_overflow_yet", 64'(bus.overflow), 64'd0);
    drive_enq(32'h2ff, 1'b1);
    tick();
    check("t2_ovf_count", 64'(bus.count), 64'd8);
    check("t2_overflow", 64'(bus.overflow), 64'd1);
    check("t2_head_pc", 64'(bus.deq_pc), 64'h200);

    // 3: full with simultaneous enq and deq
    drive_enq(32'h300, 1'b1);
    bus.deq_ready = 1'b1;
    tick();
    bus.enq_valid = 1'b0;
    check("t3_count", 64'(bus.count), 64'd8);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("t3_head%0d", k), 64'(bus.deq_pc), 64'h201 + 64'(k));
      tick();
    end
    check("t3_new_uop_pc", 64'(bus.deq_pc), 64'h300);
    check("t3_count1", 64'(bus.count), 64'd1);
    check("t3_stall_clear", 64'(bus.stall_out), 64'd0);
    tick();
    bus.deq_ready = 1'b0;
    check("t3_empty", 64'(bus.deq_valid), 64'd0);

    // 4: stream 20 uops, frontend honours stall_out, rename ready toggles 1,0
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 20 && cyc < 200) begin
      bus.deq_ready = (cyc % 2 == 0);
      if (sent < 20 && !bus.stall_out) begin
        drive_enq(32'h400 + 32'(sent), 1'(sent % 3 == 2));
      end else begin
        bus.enq_valid = 1'b0;
      end
      if (bus.deq_valid && bus.deq_ready) begin
        check($sformatf("t4_pc%0d", recv), 64'(bus.deq_pc), 64'h400 + 64'(recv));
        recv++;
      end
      if (bus.enq_valid) sent++;
      tick();
      cyc++;
    end
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    check("t4_received", 64'(recv), 64'd20);
    check("t4_count", 64'(bus.count), 64'd0);
    check("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

    // 5: flush with count=5 and a same-cycle enqueue
    for (int i = 0; i < 5; i++) begin
      drive_enq(32'h500 + 32'(i), 1'b1);
      tick();
    end
    bus.enq_valid = 1'b0;
    check("t5_count5", 64'(bus.count), 64'd5);
    drive_enq(32'h5ff, 1'b1);
    bus.flush     = 1'b1;
    bus.deq_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    check("t5_count0", 64'(bus.count), 64'd0);
    check("t5_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("t5_stall", 64'(bus.stall_out), 64'd0);
    check("t5_overflow_kept", 64'(bus.overflow), 64'd1);
    drive_enq(32'h600, 1'b1);
    tick();
    bus.enq_valid = 1'b0;
    check("t5_post_flush_pc", 64'(bus.deq_pc), 64'h600);
    check("t5_post_flush_count", 64'(bus.count), 64'd1);

    // 6: asynchronous reset between edges with count=3
    for (int i = 0; i < 2; i++) begin
      drive_enq(32'h700 + 32'(i), 1'b1);
      tick();
    end
    bus.enq_valid = 1'b0;
    check("t6_count3", 64'(bus.count), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("t6_async_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("t6_async_count", 64'(bus.count), 64'd0);
    check("t6_async_overflow", 64'(bus.overflow), 64'd0);
    check("t6_async_stall", 64'(bus.stall_out), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
